// File: rtl/uart_sim_pkg.sv
// Shared types and elaboration-time helpers for the simulation UART receiver.
package uart_sim_pkg;

    // Receiver FSM states; IDLE is the reset encoding.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    localparam int DATA_BITS = 8;

    // Ceiling log2, never below 1 so that derived vector widths stay legal.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Whole clocks per bit; the fractional part is dropped.
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO for received bytes.
// dout always shows the oldest entry and reads as zero while empty.
module uart_rx_fifo
    import uart_sim_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, equal
    // index with differing wrap bit means full.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO
    // still accepts a byte when it is also being read.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers on accepted operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage array; contents are only visible through dout when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_rx_monitor.sv
// UART 8N1 receiver: two-flop synchronizer, down-counting baud timer,
// start/data/stop/break FSM and a byte FIFO with a valid/ready port.
//
// Consumer handshake: valid is high whenever a byte is queued and data holds
// the oldest byte; the byte is consumed on a rising clk edge where
// valid && ready. ready while valid is low does nothing, and data/valid do
// not depend combinationally on ready.
module uart_rx_monitor
    import uart_sim_pkg::*;
#(
    parameter int CLK_FREQ     = 100000000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD),
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int            CW        = clog2(CLKS_PER_BIT);
    // Half a bit from the detected falling edge lands on the start-bit centre.
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    logic                 rx_meta;
    logic                 rx_s;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [CW-1:0]        baud_cnt;
    logic [CW-1:0]        baud_cnt_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 tick;
    logic                 push_byte;
    logic                 frame_err_set;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 pop;

    assign tick  = (baud_cnt == '0);
    assign valid = !fifo_empty;
    assign pop   = valid && ready;

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Baud timer, bit counter and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            baud_cnt  <= baud_cnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
        end
    end

    // Next state and datapath updates; every sample happens on a tick.
    always_comb begin
        state_next    = state;
        baud_cnt_next = tick ? FULL_LOAD : baud_cnt - CW'(1);
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        unique case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next    = START;
                    baud_cnt_next = HALF_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s) begin
                        // Line was high again at the start-bit centre: a glitch.
                        state_next = IDLE;
                    end else begin
                        state_next    = DATA;
                        bit_cnt_next  = '0;
                        baud_cnt_next = FULL_LOAD;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    // LSB arrives first, so shift in from the top.
                    shift_next    = {rx_s, shift_reg[DATA_BITS-1:1]};
                    baud_cnt_next = FULL_LOAD;
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next = rx_s ? IDLE : BREAK;
                end
            end
            BREAK: begin
                // Hold here until the line returns high so a long break
                // produces a single framing error.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM outputs: byte push, framing-error request and busy flag.
    always_comb begin
        push_byte     = (state == STOP) && tick && rx_s;
        frame_err_set = (state == STOP) && tick && !rx_s;
        busy          = (state != IDLE);
    end

    // Status flags: one-cycle framing-error pulse and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= frame_err_set;
            if (push_byte && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_byte),
        .din   (shift_reg),
        .pop   (pop),
        .dout  (data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
